// File: rtl/gemv_tile_ctrl.sv
// Tile sequencer for y = W*x on a TILE_SIZE x TILE_SIZE array: buffers x, fetches W tiles,
// chains the partial sum through the array and streams finished row blocks of y.
module gemv_tile_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int TILE_SIZE  = 16,
    parameter int OUT_SIZE   = 40,
    parameter int IN_SIZE    = 256,
    localparam int N_ROWBLK  = (OUT_SIZE + TILE_SIZE - 1) / TILE_SIZE,
    localparam int N_COLBLK  = IN_SIZE / TILE_SIZE,
    localparam int RBW       = (N_ROWBLK > 1) ? $clog2(N_ROWBLK) : 1,
    localparam int CBW       = (N_COLBLK > 1) ? $clog2(N_COLBLK) : 1,
    localparam int VW        = TILE_SIZE * DATA_WIDTH,
    localparam int TW        = TILE_SIZE * TILE_SIZE * DATA_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    input  logic           x_valid,
    output logic           x_ready,
    input  logic [VW-1:0]  x_data,
    output logic           w_req,
    output logic [RBW-1:0] w_rb,
    output logic [CBW-1:0] w_cb,
    input  logic           w_gnt,
    input  logic [TW-1:0]  w_tile,
    output logic [2:0]     arr_mode,
    output logic           arr_valid_in,
    output logic           arr_accumulate_en,
    output logic [TW-1:0]  arr_a_in,
    output logic [VW-1:0]  arr_b_vec,
    output logic [VW-1:0]  arr_acc_in_vec,
    input  logic           arr_done_tile,
    input  logic [VW-1:0]  arr_result_vec,
    output logic           y_valid,
    input  logic           y_ready,
    output logic [RBW-1:0] y_rb,
    output logic [VW-1:0]  y_data
);

    localparam int IW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_X, S_REQ_W, S_ISSUE, S_WAIT, S_CAPTURE, S_OUT, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [RBW-1:0] rb_q, rb_d;
    logic [CBW-1:0] cb_q, cb_d;
    logic [CBW-1:0] xcnt_q, xcnt_d;
    logic [IW-1:0]  iss_q, iss_d;
    logic [TW-1:0]  a_reg_q, a_reg_d;
    logic [VW-1:0]  psum_q, psum_d;
    logic [VW-1:0]  x_buf_q [N_COLBLK];
    logic           x_we;
    logic [TW-1:0]  tile_masked;

    // Rows beyond OUT_SIZE in the last row block are zeroed so padded y rows read 0.
    for (genvar gi = 0; gi < TILE_SIZE; gi++) begin : g_row
        logic row_live;
        assign row_live = (int'(rb_q) * TILE_SIZE + gi) < OUT_SIZE;
        assign tile_masked[gi*VW +: VW] = row_live ? w_tile[gi*VW +: VW] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rb_q    <= '0;
            cb_q    <= '0;
            xcnt_q  <= '0;
            iss_q   <= '0;
            a_reg_q <= '0;
            psum_q  <= '0;
            for (int k = 0; k < N_COLBLK; k++) begin
                x_buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            rb_q    <= rb_d;
            cb_q    <= cb_d;
            xcnt_q  <= xcnt_d;
            iss_q   <= iss_d;
            a_reg_q <= a_reg_d;
            psum_q  <= psum_d;
            if (x_we) begin
                x_buf_q[xcnt_q] <= x_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rb_d    = rb_q;
        cb_d    = cb_q;
        xcnt_d  = xcnt_q;
        iss_d   = iss_q;
        a_reg_d = a_reg_q;
        psum_d  = psum_q;
        x_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_X;
                    rb_d    = '0;
                    cb_d    = '0;
                    xcnt_d  = '0;
                end
            end
            S_LOAD_X: begin
                if (x_valid) begin
                    x_we = 1'b1;
                    if (xcnt_q == CBW'(N_COLBLK - 1)) state_d = S_REQ_W;
                    else                               xcnt_d  = xcnt_q + CBW'(1);
                end
            end
            S_REQ_W: begin
                if (w_gnt) begin
                    a_reg_d = tile_masked;
                    iss_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (iss_q == IW'(TILE_SIZE - 1)) state_d = S_WAIT;
                else                              iss_d   = iss_q + IW'(1);
            end
            S_WAIT: begin
                if (arr_done_tile) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                psum_d = arr_result_vec;
                if (cb_q != CBW'(N_COLBLK - 1)) begin
                    cb_d    = cb_q + CBW'(1);
                    state_d = S_REQ_W;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (y_ready) begin
                    psum_d = '0;
                    cb_d   = '0;
                    if (rb_q != RBW'(N_ROWBLK - 1)) begin
                        rb_d    = rb_q + RBW'(1);
                        state_d = S_REQ_W;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy              = (state_q != S_IDLE) && (state_q != S_DONE);
        done              = (state_q == S_DONE);
        x_ready           = (state_q == S_LOAD_X);
        w_req             = (state_q == S_REQ_W);
        w_rb              = rb_q;
        w_cb              = cb_q;
        arr_mode          = 3'b000;
        arr_valid_in      = (state_q == S_ISSUE);
        arr_accumulate_en = (cb_q != '0);
        arr_a_in          = a_reg_q;
        arr_b_vec         = x_buf_q[cb_q];
        arr_acc_in_vec    = psum_q;
        y_valid           = (state_q == S_OUT);
        y_rb              = rb_q;
        y_data            = psum_q;
    end

endmodule

// File: tb/tb_gemv_tile_ctrl.sv
// Bench for gemv_tile_ctrl: behavioural array and W-source models around the DUT,
// y checked against a plain dot-product reference of W*x.
module tb_gemv_tile_ctrl;
    localparam int DW      = 16;
    localparam int TS      = 16;
    localparam int OS      = 40;
    localparam int IS      = 256;
    localparam int NRB     = 3;
    localparam int NCB     = 16;
    localparam int VW      = TS * DW;
    localparam int TW      = TS * VW;
    localparam int ARR_LAT = 3;

    logic          clk = 1'b0;
    logic          rst, start, busy, done, x_valid, x_ready;
    logic [VW-1:0] x_data;
    logic          w_req, w_gnt;
    logic [1:0]    w_rb, y_rb;
    logic [3:0]    w_cb;
    logic [TW-1:0] w_tile, arr_a_in;
    logic [2:0]    arr_mode;
    logic          arr_valid_in, arr_accumulate_en;
    logic [VW-1:0] arr_b_vec, arr_acc_in_vec, y_data;
    logic          arr_done_tile = 1'b0;
    logic [VW-1:0] arr_result_vec = '0;
    logic          y_valid, y_ready;

    always #5 clk = ~clk;

    gemv_tile_ctrl #(.DATA_WIDTH(DW), .TILE_SIZE(TS), .OUT_SIZE(OS), .IN_SIZE(IS)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .w_req(w_req), .w_rb(w_rb), .w_cb(w_cb), .w_gnt(w_gnt), .w_tile(w_tile),
        .arr_mode(arr_mode), .arr_valid_in(arr_valid_in), .arr_accumulate_en(arr_accumulate_en),
        .arr_a_in(arr_a_in), .arr_b_vec(arr_b_vec), .arr_acc_in_vec(arr_acc_in_vec),
        .arr_done_tile(arr_done_tile), .arr_result_vec(arr_result_vec),
        .y_valid(y_valid), .y_ready(y_ready), .y_rb(y_rb), .y_data(y_data)
    );

    int W [OS][IS];
    int X [IS];
    int pad_val, wver;
    bit gnt_always, gnt_delay, spur_en, hold_en, clr;
    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- W source: tile contents follow the requested block ----------------
    function automatic logic [TW-1:0] build_tile(input logic [1:0] rb, input logic [3:0] cb,
                                                 input int ver, input int pad);
        logic [TW-1:0] t;
        int r;
        t = '0;
        for (int i = 0; i < TS; i++) begin
            r = int'(rb) * TS + i;
            for (int j = 0; j < TS; j++)
                t[(i*TS+j)*DW +: DW] = (r < OS) ? DW'(W[r][int'(cb)*TS+j]) : DW'(pad);
        end
        if (ver < 0) t = '0;
        return t;
    endfunction

    assign w_tile = build_tile(w_rb, w_cb, wver, pad_val);

    int wcnt = 0;
    always @(posedge clk) begin
        if (!w_req || w_gnt) wcnt <= gnt_delay ? int'($urandom_range(0, 5)) : 0;
        else if (wcnt > 0)   wcnt <= wcnt - 1;
    end
    assign w_gnt = gnt_always ? 1'b1 : (w_req && wcnt == 0);

    // ---------------- array model: acc + A*b, wrapped to DW bits ----------------
    function automatic logic [VW-1:0] array_calc(input logic [TW-1:0] a, input logic [VW-1:0] b,
                                                 input logic [VW-1:0] acc, input logic en);
        logic [VW-1:0] r;
        logic signed [DW-1:0] ae, be, ce;
        int s;
        r = '0;
        for (int i = 0; i < TS; i++) begin
            ce = acc[i*DW +: DW];
            s  = en ? int'(ce) : 0;
            for (int j = 0; j < TS; j++) begin
                ae = a[(i*TS+j)*DW +: DW];
                be = b[j*DW +: DW];
                s += int'(ae) * int'(be);
            end
            r[i*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    int run, lat, pulses, badw, accen0;
    logic [VW-1:0] res_next;
    always @(negedge clk) begin
        if (rst || clr) begin
            run = 0; lat = -1; pulses = 0; badw = 0; accen0 = 0;
            arr_done_tile <= 1'b0;
        end else begin
            arr_done_tile <= 1'b0;
            if (arr_valid_in) begin
                if (run == 0) begin
                    pulses++;
                    if (!arr_accumulate_en) accen0++;
                    res_next = array_calc(arr_a_in, arr_b_vec, arr_acc_in_vec, arr_accumulate_en);
                end
                run++;
                if (spur_en && run == 3) arr_done_tile <= 1'b1;
            end else if (run != 0) begin
                if (run != TS) badw++;
                run = 0;
                lat = ARR_LAT;
            end
            if (lat == 0) begin
                arr_result_vec <= res_next;
                arr_done_tile  <= 1'b1;
                lat = -1;
            end else if (lat > 0) begin
                lat--;
            end
        end
    end

    // ---------------- downstream: optional back-pressure on block 1 ----------------
    int hold_cnt = 0;
    always @(posedge clk) begin
        if (rst || clr)                                          hold_cnt <= 0;
        else if (hold_en && y_valid && !y_ready && y_rb == 2'd1) hold_cnt <= hold_cnt + 1;
    end
    assign y_ready = !(hold_en && y_valid && y_rb == 2'd1 && hold_cnt < 10);

    logic [VW-1:0] yq_data [$];
    int            yq_rb [$];
    int            done_cnt, busy_at_done, y_change, wreq_in_hold;
    bit            y_wait;
    logic [VW-1:0] y_prev;
    logic [1:0]    y_prev_rb;
    always @(negedge clk) begin
        if (rst || clr) begin
            yq_data.delete(); yq_rb.delete();
            done_cnt = 0; busy_at_done = 0; y_change = 0; wreq_in_hold = 0; y_wait = 0;
        end else begin
            if (done) begin
                done_cnt++;
                if (busy) busy_at_done++;
            end
            if (y_wait && w_req) wreq_in_hold++;
            if (y_valid) begin
                if (y_wait && (y_data !== y_prev || y_rb !== y_prev_rb)) y_change++;
                if (y_ready) begin
                    yq_data.push_back(y_data);
                    yq_rb.push_back(int'(y_rb));
                    y_wait = 0;
                end else begin
                    y_wait = 1; y_prev = y_data; y_prev_rb = y_rb;
                end
            end
        end
    end

    // ---------------- reference and helpers ----------------
    function automatic logic [VW-1:0] exp_block(input int rb);
        logic [VW-1:0] v;
        int s, r;
        v = '0;
        for (int i = 0; i < TS; i++) begin
            r = rb * TS + i;
            s = 0;
            if (r < OS) for (int c = 0; c < IS; c++) s += W[r][c] * X[c];
            v[i*DW +: DW] = s[DW-1:0];
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        clr = 1'b1; tick(1); clr = 1'b0;
    endtask

    task automatic fill_const();
        for (int r = 0; r < OS; r++) for (int c = 0; c < IS; c++) W[r][c] = 1;
        for (int c = 0; c < IS; c++) X[c] = 2;
        wver++;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < OS; r++)
            for (int c = 0; c < IS; c++) W[r][c] = int'($urandom_range(0, 7)) - 4;
        for (int c = 0; c < IS; c++) X[c] = int'($urandom_range(0, 7)) - 4;
        wver++;
    endtask

    task automatic load_x(input bit gaps);
        for (int k = 0; k < NCB; k++) begin
            if (gaps) begin
                x_valid = 1'b0;
                repeat ($urandom_range(0, 3)) tick(1);
            end
            x_valid = 1'b1;
            for (int j = 0; j < TS; j++) x_data[j*DW +: DW] = DW'(X[k*TS+j]);
            tick(1);
        end
        x_valid = 1'b0;
    endtask

    task automatic run_gemv(input bit gaps, input bit junk, input bit busy_start, output bit ok);
        int c;
        start = 1'b1; tick(1); start = 1'b0;
        load_x(gaps);
        if (junk) begin
            x_valid = 1'b1;
            x_data  = {8{$urandom()}};
        end
        if (busy_start) begin
            tick(5); start = 1'b1; tick(1); start = 1'b0;
        end
        ok = 1'b0;
        c  = 0;
        while (c < 20000) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick(1);
            c++;
        end
        x_valid = 1'b0;
        tick(2);
    endtask

    task automatic check_y(input string tag);
        check({tag, "_nblk"}, VW'(yq_rb.size()), VW'(NRB));
        for (int b = 0; b < yq_rb.size() && b < NRB; b++) begin
            check($sformatf("%s_rb%0d", tag, b), VW'(yq_rb[b]), VW'(b));
            check($sformatf("%s_y%0d", tag, b), yq_data[b], exp_block(b));
        end
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_ctrl"}, VW'({busy, done, x_ready, w_req, w_rb, w_cb, arr_mode,
                                   arr_valid_in, arr_accumulate_en, y_valid, y_rb}), '0);
        check({tag, "_vec"}, VW'({arr_a_in == '0, arr_b_vec == '0, arr_acc_in_vec == '0,
                                  y_data == '0}), VW'(4'hF));
    endtask

    initial begin
        bit ok;
        int c;
        rst = 1'b1; start = 1'b0; x_valid = 1'b0; x_data = '0;
        gnt_always = 1'b1; gnt_delay = 1'b0; spur_en = 1'b0; hold_en = 1'b0; clr = 1'b0;
        pad_val = 0; wver = 0;
        fill_const();
        tick(3);
        check_outs_zero("reset");
        rst = 1'b0;
        tick(1);

        // all-ones W, x=2, grant and ready always high
        run_gemv(1'b0, 1'b0, 1'b0, ok);
        check("A_done_seen", VW'(ok), VW'(1));
        check_y("A");
        if (yq_data.size() > 0) check("A_row0_512", VW'(yq_data[0][DW-1:0]), VW'(512));
        check("A_done_cnt", VW'(done_cnt), VW'(1));
        check("A_busy_at_done", VW'(busy_at_done), '0);
        check("A_pulses", VW'(pulses), VW'(NRB * NCB));
        check("A_badwidth", VW'(badw), '0);
        check("A_accen0", VW'(accen0), VW'(NRB));
        clr_pulse();

        // random data, padded rows 0x7FFF, delayed grants, stray done, y back-pressure
        fill_rand();
        pad_val = 32'h7FFF; gnt_always = 1'b0; gnt_delay = 1'b1; spur_en = 1'b1; hold_en = 1'b1;
        run_gemv(1'b1, 1'b0, 1'b0, ok);
        check("B_done_seen", VW'(ok), VW'(1));
        check_y("B");
        check("B_pulses", VW'(pulses), VW'(NRB * NCB));
        check("B_badwidth", VW'(badw), '0);
        check("B_accen0", VW'(accen0), VW'(NRB));
        check("B_hold_cycles", VW'(hold_cnt), VW'(10));
        check("B_y_stable", VW'(y_change), '0);
        check("B_wreq_in_hold", VW'(wreq_in_hold), '0);
        clr_pulse();
        hold_en = 1'b0; spur_en = 1'b0;

        // constant data again with gaps, junk x beats and a start while busy
        fill_const();
        run_gemv(1'b1, 1'b1, 1'b1, ok);
        check("C_done_seen", VW'(ok), VW'(1));
        check_y("C");
        check("C_done_cnt", VW'(done_cnt), VW'(1));
        check("C_pulses", VW'(pulses), VW'(NRB * NCB));
        clr_pulse();

        // reset during ISSUE of tile (rb=1, cb=5), then a clean run
        gnt_always = 1'b1; gnt_delay = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        load_x(1'b0);
        c = 0;
        while (c < 20000 && !(arr_valid_in && w_rb == 2'd1 && w_cb == 4'd5)) begin
            tick(1);
            c++;
        end
        check("D_reached_issue", VW'(c < 20000), VW'(1));
        rst = 1'b1;
        tick(1);
        check_outs_zero("D_midreset");
        rst = 1'b0;
        tick(1);
        run_gemv(1'b0, 1'b0, 1'b1, ok);
        check("D_done_seen", VW'(ok), VW'(1));
        check_y("D");
        check("D_done_cnt", VW'(done_cnt), VW'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gemv_tile_ctrl.md
Name: gemv_tile_ctrl

Overview:
- Tile sequencer for mode-000 GEMV, y = W × x, with OUT_SIZE×IN_SIZE weights. It sits directly upstream of recfg_array and also consumes that array's output.
- Buffers x, fetches W tiles and drives the array one TILE_SIZE×TILE_SIZE tile at a time.
- Holds the running partial sum and feeds it back through acc_in_vec.
- Streams each finished row block of y downstream.

Parameters:
- DATA_WIDTH, 16, element width (signed two's complement).
- TILE_SIZE, 16, array tile edge.
- OUT_SIZE, 40, rows of W (length of y).
- IN_SIZE, 256, columns of W (length of x); must be a multiple of TILE_SIZE.
- Derived: N_ROWBLK = ceil(OUT_SIZE/TILE_SIZE) = 3; N_COLBLK = IN_SIZE/TILE_SIZE = 16.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a GEMV when idle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last y block is accepted.
- x_valid  in  1  x segment beat valid.
- x_ready  out  1  ready for an x beat.
- x_data  in  TILE_SIZE*DATA_WIDTH  x segment; element j is in bits [j*DW +: DW].
- w_req  out  1  W tile request.
- w_rb  out  $clog2(N_ROWBLK)  requested row block.
- w_cb  out  $clog2(N_COLBLK)  requested column block.
- w_gnt  in  1  tile data valid this cycle.
- w_tile  in  TILE_SIZE*TILE_SIZE*DATA_WIDTH  tile; element (i,j) is at index i*TILE_SIZE+j.
- arr_mode  out  3  constant 3'b000.
- arr_valid_in  out  1  array valid_in.
- arr_accumulate_en  out  1  array accumulate_en.
- arr_a_in  out  TILE_SIZE*TILE_SIZE*DATA_WIDTH  array a_in.
- arr_b_vec  out  TILE_SIZE*DATA_WIDTH  array b_vec.
- arr_acc_in_vec  out  TILE_SIZE*DATA_WIDTH  array acc_in_vec.
- arr_done_tile  in  1  array done_tile.
- arr_result_vec  in  TILE_SIZE*DATA_WIDTH  array result_out_vec.
- y_valid  out  1  y block valid.
- y_ready  in  1  downstream ready.
- y_rb  out  $clog2(N_ROWBLK)  row block index of y_data.
- y_data  out  TILE_SIZE*DATA_WIDTH  y rows rb*TILE_SIZE+i.

Behaviour:
- Reset: every output is 0 and the FSM goes to IDLE. The x buffer and psum are cleared. Reset takes priority in any state, including mid-tile.
- FSM states and transitions:
  - IDLE: start moves to LOAD_X, sets busy=1, rb=cb=0.
  - LOAD_X: x_ready=1. Each x_valid&&x_ready beat k writes x_buf[k*TS +: TS]. After N_COLBLK beats, go to REQ_W.
  - REQ_W: w_req=1 with w_rb=rb, w_cb=cb, held until w_gnt. On w_gnt, latch the tile into a_reg, dropping w_req the same edge, then go to ISSUE. Rows with rb*TS+i ≥ OUT_SIZE are forced to 0 in a_reg.
  - ISSUE: arr_valid_in=1 for exactly TILE_SIZE consecutive cycles, counted by a counter, then go to WAIT.
    - arr_a_in=a_reg.
    - arr_b_vec=x_buf segment cb.
    - arr_acc_in_vec=psum.
    - arr_accumulate_en=(cb!=0).
    - These inputs stay stable from the first ISSUE cycle until CAPTURE completes.
  - WAIT: arr_valid_in=0. When arr_done_tile is sampled 1, go to CAPTURE. arr_done_tile seen in ISSUE is ignored.
  - CAPTURE (1 cycle): psum ← arr_result_vec.
    - If cb<N_COLBLK-1: cb++ and go to REQ_W.
    - Else: go to OUT.
  - OUT: y_valid=1, y_data=psum, y_rb=rb, all held stable until y_ready.
    - On handshake: clear psum, set cb=0.
    - If rb<N_ROWBLK-1: rb++ and go to REQ_W.
    - Else: go to DONE.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Arithmetic: no arithmetic in this block. psum is DATA_WIDTH and copies the array's result verbatim; the array owns truncation.
- Padding rows: y_data rows ≥ OUT_SIZE in the last block are 0 (guaranteed by a_reg masking and a zeroed psum).
- start while busy: ignored. x_valid outside LOAD_X: ignored (x_ready=0). w_gnt outside REQ_W: ignored.
- Latency per tile: grant→first valid is 1 cycle; ISSUE is TILE_SIZE cycles; then array latency plus 1 capture cycle.

Test Plan:
- W all 1, x all 2, w_gnt and y_ready always 1 → three y blocks (rb=0,1,2). Rows 0..39 = 512; block-2 rows 8..15 = 0; done pulses once; busy falls the same cycle.
- Random W and x in [-4,3] at 40×256 → y matches a software dot-product model, 0 mismatches. arr_accumulate_en=0 only on cb=0 tiles (3 of 48).
- Upstream tile fills rows 40..47 with 0x7FFF → those y rows still read 0.
- w_gnt delayed by random 0–5 cycles and x_valid gapped → result identical to the first scenario. arr_valid_in pulses are exactly 16 cycles wide, 48 pulses total.
- y_ready held low for 10 cycles on block 1 → y_data/y_rb stable throughout; no new w_req issued until the handshake.
- rst asserted in the ISSUE phase of tile (rb=1,cb=5) → next cycle all outputs 0 and FSM in IDLE. A fresh start with the first scenario's data then completes correctly (512s). A start pulse sent while busy has no effect.
